decode_stage: RTL

- Registered instruction-decode stage (ID/EX pipeline register) for the pipelined processor.
- Decodes one instruction per cycle into the same control set used today, plus:
  - destination register selection
  - sign-extended immediate
  - valid/ready handshake
  - load-use interlock sized by a load-latency parameter
  - branch flush
  - saturating stall counter
- Sits between the fetch stage and the execute stage.

---
 rtl/decode_stage_pkg.sv | 64 ++++++
 rtl/decode_logic.sv | 93 +++++++++
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared opcode/funct encodings, ALU and branch codes, and the decoded
//   control-flag bundle used by decode_logic and decode_stage.
package decode_stage_pkg;

    localparam int LOAD_LATENCY_MAX = 4;

    localparam int OP_WIDTH       = 6;
    localparam int FUNCT_WIDTH    = 6;
    localparam int SHAMT_WIDTH    = 5;
    localparam int ALU_CODE_WIDTH = 3;
    localparam int BR_CODE_WIDTH  = 2;

    localparam logic [OP_WIDTH-1:0] OP_ALU  = 6'h00;
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = 6'h04;
    localparam logic [OP_WIDTH-1:0] OP_BNE  = 6'h05;
    localparam logic [OP_WIDTH-1:0] OP_ADDI = 6'h08;
    localparam logic [OP_WIDTH-1:0] OP_ANDI = 6'h0C;
    localparam logic [OP_WIDTH-1:0] OP_ORI  = 6'h0D;
    localparam logic [OP_WIDTH-1:0] OP_LD   = 6'h23;
    localparam logic [OP_WIDTH-1:0] OP_ST   = 6'h2B;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL = 6'h00;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL = 6'h02;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT = 6'h2A;

    // ADD and UNTAKEN are encoded as zero so a cleared register decodes
    // as a harmless add with no branch.
    typedef enum logic [ALU_CODE_WIDTH-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_code_e;

    typedef enum logic [BR_CODE_WIDTH-1:0] {
        BR_UNTAKEN = 2'd0,
        BR_EQ      = 2'd1,
        BR_NE      = 2'd2
    } br_code_e;

    typedef struct packed {
        alu_code_e alu_code;
        br_code_e  br_code;
        logic      pc_wr_en;
        logic      is_load;
        logic      is_store;
        logic      is_src_a_rt;
        logic      rf_wr_en;
        logic      is_alu_in_const;
    } decode_ctrl_t;

    function automatic logic is_shift(input alu_code_e code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/decode_logic.sv
// decode_logic
//   Purely combinational instruction decoder.
//   insn              : instruction word
//   op/rs/rt/shamt/funct : raw fields
//   dst               : destination register (rt for LD/ADDI/ANDI/ORI, else rd)
//   constant          : sign-extended 16-bit immediate
//   ctrl              : ALU/branch codes and control flags
//   rs_used/rt_used   : which source registers the instruction reads
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int INSN_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5
) (
    input  logic [INSN_WIDTH-1:0]    insn,
    output logic [OP_WIDTH-1:0]      op,
    output logic [REG_NUM_WIDTH-1:0] rs,
    output logic [REG_NUM_WIDTH-1:0] rt,
    output logic [SHAMT_WIDTH-1:0]   shamt,
    output logic [FUNCT_WIDTH-1:0]   funct,
    output logic [REG_NUM_WIDTH-1:0] dst,
    output logic [DATA_WIDTH-1:0]    constant,
    output decode_ctrl_t             ctrl,
    output logic                     rs_used,
    output logic                     rt_used
);

    logic [REG_NUM_WIDTH-1:0] rd;

    assign op       = insn[31:26];
    assign rs       = REG_NUM_WIDTH'(insn[25:21]);
    assign rt       = REG_NUM_WIDTH'(insn[20:16]);
    assign rd       = REG_NUM_WIDTH'(insn[15:11]);
    assign shamt    = insn[10:6];
    assign funct    = insn[5:0];
    assign constant = DATA_WIDTH'($signed(insn[15:0]));

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        ctrl          = '0;
        ctrl.alu_code = ALU_ADD;
        ctrl.br_code  = BR_UNTAKEN;
        dst           = rd;
        rt_used       = 1'b0;
        case (op)
            OP_ALU: begin
                ctrl.rf_wr_en = 1'b1;
                rt_used       = 1'b1;
                case (funct)
                    FUNCT_SRL: ctrl.alu_code = ALU_SRL;
                    FUNCT_ADD: ctrl.alu_code = ALU_ADD;
                    FUNCT_SUB: ctrl.alu_code = ALU_SUB;
                    FUNCT_AND: ctrl.alu_code = ALU_AND;
                    FUNCT_OR:  ctrl.alu_code = ALU_OR;
                    FUNCT_SLT: ctrl.alu_code = ALU_SLT;
                    default:   ctrl.alu_code = ALU_SLL; // unknown funct behaves as SLL
                endcase
                // Shifts take rt as operand A and shamt as the constant operand.
                if (is_shift(ctrl.alu_code)) begin
                    ctrl.is_src_a_rt     = 1'b1;
                    ctrl.is_alu_in_const = 1'b1;
                end
            end
            OP_LD: begin
                dst                  = rt;
                ctrl.is_load         = 1'b1;
                ctrl.rf_wr_en        = 1'b1;
                ctrl.is_alu_in_const = 1'b1;
            end
            OP_ST: begin
                ctrl.is_store        = 1'b1;
                ctrl.is_alu_in_const = 1'b1;
                rt_used              = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                dst                  = rt;
                ctrl.rf_wr_en        = 1'b1;
                ctrl.is_alu_in_const = 1'b1;
                if (op == OP_ANDI) ctrl.alu_code = ALU_AND;
                if (op == OP_ORI)  ctrl.alu_code = ALU_OR;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.br_code  = (op == OP_BEQ) ? BR_EQ : BR_NE;
                ctrl.pc_wr_en = 1'b1;
                rt_used       = 1'b1;
            end
            default: ;
        endcase
        rs_used = !ctrl.is_src_a_rt;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered decode stage (ID/EX register) with valid/ready handshake,
//   load-use interlock, branch flush and a saturating stall counter.
//   clk, rst         : clock, asynchronous active-low reset
//   in_valid/in_insn : instruction offered by fetch; in_ready = accepted
//   flush            : taken branch in EX; kills stage and pending loads
//   ex_ready         : execute stage accepts the output register
//   out_*            : registered decoded instruction, out_valid = live
//   stall_count      : number of hazard bubbles inserted (saturating)
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int INSN_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5,
    parameter int LOAD_LATENCY  = 1,   // 1..LOAD_LATENCY_MAX
    parameter int CNT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [INSN_WIDTH-1:0]     in_insn,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic                      ex_ready,
    output logic                      out_valid,
    output logic [OP_WIDTH-1:0]       out_op,
    output logic [REG_NUM_WIDTH-1:0]  out_rs,
    output logic [REG_NUM_WIDTH-1:0]  out_rt,
    output logic [SHAMT_WIDTH-1:0]    out_shamt,
    output logic [FUNCT_WIDTH-1:0]    out_funct,
    output logic [REG_NUM_WIDTH-1:0]  out_dst,
    output logic [DATA_WIDTH-1:0]     out_constant,
    output logic [ALU_CODE_WIDTH-1:0] out_alu_code,
    output logic [BR_CODE_WIDTH-1:0]  out_br_code,
    output logic                      out_pc_wr_en,
    output logic                      out_is_load,
    output logic                      out_is_store,
    output logic                      out_is_src_a_rt,
    output logic                      out_rf_wr_en,
    output logic                      out_is_alu_in_const,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    typedef struct packed {
        logic                     vld;
        logic [REG_NUM_WIDTH-1:0] rn;
    } trk_entry_t;

    logic [OP_WIDTH-1:0]      dec_op;
    logic [REG_NUM_WIDTH-1:0] dec_rs, dec_rt, dec_dst;
    logic [SHAMT_WIDTH-1:0]   dec_shamt;
    logic [FUNCT_WIDTH-1:0]   dec_funct;
    logic [DATA_WIDTH-1:0]    dec_constant;
    decode_ctrl_t             dec_ctrl;
    logic                     dec_rs_used, dec_rt_used;

    logic                     out_valid_q, out_valid_d;
    logic [OP_WIDTH-1:0]      op_q, op_d;
    logic [REG_NUM_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
    logic [SHAMT_WIDTH-1:0]   shamt_q, shamt_d;
    logic [FUNCT_WIDTH-1:0]   funct_q, funct_d;
    logic [DATA_WIDTH-1:0]    constant_q, constant_d;
    decode_ctrl_t             ctrl_q, ctrl_d;
    trk_entry_t               trk_q [LOAD_LATENCY];
    trk_entry_t               trk_d [LOAD_LATENCY];
    logic [CNT_WIDTH-1:0]     stall_q, stall_d;

    logic adv, hazard_src, hazard;

    decode_logic #(
        .INSN_WIDTH    (INSN_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_NUM_WIDTH (REG_NUM_WIDTH)
    ) u_decode_logic (
        .insn     (in_insn),
        .op       (dec_op),
        .rs       (dec_rs),
        .rt       (dec_rt),
        .shamt    (dec_shamt),
        .funct    (dec_funct),
        .dst      (dec_dst),
        .constant (dec_constant),
        .ctrl     (dec_ctrl),
        .rs_used  (dec_rs_used),
        .rt_used  (dec_rt_used)
    );

    function automatic logic reads_reg(input logic [REG_NUM_WIDTH-1:0] r);
        return (dec_rs_used && dec_rs == r) || (dec_rt_used && dec_rt == r);
    endfunction

    assign adv = !out_valid_q || ex_ready;

    // A load in the output register is always in the comparison set; the
    // tracker only adds the older loads still within LOAD_LATENCY advances.
    // Register 0 never enters the set, so it can never cause a hazard.
    always_comb begin
        hazard_src = 1'b0;
        if (out_valid_q && ctrl_q.is_load && dst_q != '0 && reads_reg(dst_q))
            hazard_src = 1'b1;
        for (int i = 0; i < LOAD_LATENCY - 1; i++)
            if (trk_q[i].vld && reads_reg(trk_q[i].rn))
                hazard_src = 1'b1;
    end

    assign hazard   = in_valid && hazard_src;
    assign in_ready = adv && !hazard && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        shamt_d     = shamt_q;
        funct_d     = funct_q;
        dst_d       = dst_q;
        constant_d  = constant_q;
        ctrl_d      = ctrl_q;
        trk_d       = trk_q;
        stall_d     = stall_q;
        // Flush kills the stage even under back-pressure.
        if (flush) begin
            out_valid_d = 1'b0;
            trk_d       = '{default: '0};
        end else if (adv) begin
            for (int i = LOAD_LATENCY - 1; i > 0; i--)
                trk_d[i] = trk_q[i - 1];
            trk_d[0].vld = out_valid_q && ctrl_q.is_load && (dst_q != '0);
            trk_d[0].rn  = dst_q;
            out_valid_d  = in_valid && !hazard;
            if (in_valid && !hazard) begin
                op_d       = dec_op;
                rs_d       = dec_rs;
                rt_d       = dec_rt;
                shamt_d    = dec_shamt;
                funct_d    = dec_funct;
                dst_d      = dec_dst;
                constant_d = dec_constant;
                ctrl_d     = dec_ctrl;
            end
            if (hazard && stall_q != '1)
                stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            shamt_q     <= '0;
            funct_q     <= '0;
            dst_q       <= '0;
            constant_q  <= '0;
            ctrl_q      <= '0;
            // NOTE: the tracker is reset like any other state; a stale entry would stall the first instructions after reset.
            trk_q       <= '{default: '0};
            stall_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its _d from the same pre-edge state.
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            dst_q       <= dst_d;
            constant_q  <= constant_d;
            ctrl_q      <= ctrl_d;
            trk_q       <= trk_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid           = out_valid_q;
    assign out_op              = op_q;
    assign out_rs              = rs_q;
    assign out_rt              = rt_q;
    assign out_shamt           = shamt_q;
    assign out_funct           = funct_q;
    assign out_dst             = dst_q;
    assign out_constant        = constant_q;
    assign out_alu_code        = ctrl_q.alu_code;
    assign out_br_code         = ctrl_q.br_code;
    assign out_pc_wr_en        = ctrl_q.pc_wr_en;
    assign out_is_load         = ctrl_q.is_load;
    assign out_is_store        = ctrl_q.is_store;
    assign out_is_src_a_rt     = ctrl_q.is_src_a_rt;
    assign out_rf_wr_en        = ctrl_q.rf_wr_en;
    assign out_is_alu_in_const = ctrl_q.is_alu_in_const;
    assign stall_count         = stall_q;

endmodule
